// File: rtl/vga_box_rgb_gen.sv
// -----------------------------------------------------------------------------
// vga_box_rgb_gen
//
// Pixel-colour stage that sits directly after a 640x480 H/V sync generator.
// It draws one rectangle: the border in the FG colour, the interior in the
// BG colour and everything outside it black. The output is registered 3-3-2
// RGB. h_sync/v_sync are delayed through the same two pixel-tick pipeline,
// so sync and colour stay aligned.
//
// The box corners and the colours are written into shadow registers at any
// time. The shadow registers are copied into the active registers only at
// frame start (the pixel_tick where pixel_x==0 and pixel_y==0), so the
// drawn box never changes mid-frame.
//
// Optional feature: define VGA_BLINK_EN to add a frame counter that blanks
// the border (border pixels show BG) for every other block of
// 2^BLINK_LOG2 frames. When VGA_BLINK_EN is undefined, no counter is built
// and BLINK_LOG2 is unused.
//
// Ports
//   clk          in   1   system clock
//   reset        in   1   asynchronous, active-high
//   pixel_tick   in   1   pixel-rate enable; pipeline advances only when 1
//   video_on     in   1   visible-area flag
//   h_sync_in    in   1   horizontal sync from the generator
//   v_sync_in    in   1   vertical sync from the generator
//   pixel_x      in   10  current column
//   pixel_y      in   10  current row
//   cfg_we       in   1   one-clk write strobe
//   cfg_addr     in   3   0=X0 1=Y0 2=X1 3=Y1 4=FG 5=BG, 6/7 ignored
//   cfg_data     in   10  write data (FG/BG use the low 8 bits)
//   cfg_pending  out  1   shadow written but not yet committed
//   rgb          out  8   {R[2:0],G[2:0],B[1:0]}
//   h_sync       out  1   h_sync_in delayed by 2 pixel ticks
//   v_sync       out  1   v_sync_in delayed by 2 pixel ticks
// -----------------------------------------------------------------------------
module vga_box_rgb_gen #(
   parameter int         BORDER_W   = 4,
   parameter int         BLINK_LOG2 = 5,
   parameter logic [9:0] X0_RST     = 10'd100,
   parameter logic [9:0] Y0_RST     = 10'd100,
   parameter logic [9:0] X1_RST     = 10'd539,
   parameter logic [9:0] Y1_RST     = 10'd379,
   parameter logic [7:0] FG_RST     = 8'hE0,
   parameter logic [7:0] BG_RST     = 8'h03
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pixel_tick,
   input  logic       video_on,
   input  logic       h_sync_in,
   input  logic       v_sync_in,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic       cfg_we,
   input  logic [2:0] cfg_addr,
   input  logic [9:0] cfg_data,
   output logic       cfg_pending,
   output logic [7:0] rgb,
   output logic       h_sync,
   output logic       v_sync
);

   localparam logic [9:0] BW = 10'(BORDER_W);

   // shadow (CPU-written) configuration
   logic [9:0] x0_sh_r, y0_sh_r, x1_sh_r, y1_sh_r;
   logic [7:0] fg_sh_r, bg_sh_r;
   // active configuration used for drawing
   logic [9:0] x0_r, y0_r, x1_r, y1_r;
   logic [7:0] fg_r, bg_r;

   logic commit_s;
   logic wr_s;

   // stage 1 combinational results and registers
   logic       in_box_s;
   logic       on_border_s;
   logic [9:0] dx0_s, dx1_s, dy0_s, dy1_s;
   logic       in_box_r;
   logic       on_border_r;
   logic       vid_r;
   logic       hs1_r;
   logic       vs1_r;

   // stage 2 colour selection
   logic [7:0] rgb_s;

   // frame start is the tick that presents pixel (0,0)
   assign commit_s = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);
   // addresses 6 and 7 are reserved and must not touch cfg_pending
   assign wr_s     = cfg_we && (cfg_addr <= 3'd5);

   // shadow register file: written on any clk, independent of pixel_tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x0_sh_r <= X0_RST;
         y0_sh_r <= Y0_RST;
         x1_sh_r <= X1_RST;
         y1_sh_r <= Y1_RST;
         fg_sh_r <= FG_RST;
         bg_sh_r <= BG_RST;
      end else if (wr_s) begin
         case (cfg_addr)
            3'd0:    x0_sh_r <= cfg_data;
            3'd1:    y0_sh_r <= cfg_data;
            3'd2:    x1_sh_r <= cfg_data;
            3'd3:    y1_sh_r <= cfg_data;
            3'd4:    fg_sh_r <= cfg_data[7:0];
            3'd5:    bg_sh_r <= cfg_data[7:0];
            default: x0_sh_r <= x0_sh_r;
         endcase
      end
   end

   // active registers: commit reads the pre-write shadow (NBA semantics),
   // so a write on the commit clk lands for the following frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x0_r <= X0_RST;
         y0_r <= Y0_RST;
         x1_r <= X1_RST;
         y1_r <= Y1_RST;
         fg_r <= FG_RST;
         bg_r <= BG_RST;
      end else if (commit_s) begin
         x0_r <= x0_sh_r;
         y0_r <= y0_sh_r;
         x1_r <= x1_sh_r;
         y1_r <= y1_sh_r;
         fg_r <= fg_sh_r;
         bg_r <= bg_sh_r;
      end
   end

   // pending flag: a write wins over a same-clk commit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_pending <= 1'b0;
      end else if (wr_s) begin
         cfg_pending <= 1'b1;
      end else if (commit_s) begin
         cfg_pending <= 1'b0;
      end
   end

`ifdef VGA_BLINK_EN
   logic [BLINK_LOG2:0] frame_cnt_r;

   // frame counter, steps once per frame start and wraps
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt_r <= '0;
      end else if (commit_s) begin
         frame_cnt_r <= frame_cnt_r + 1'b1;
      end
   end
`endif

   // stage 1: box and border classification of the current pixel
   always_comb begin
      in_box_s    = 1'b0;
      on_border_s = 1'b0;
      // distances are only meaningful inside the box, where they cannot wrap
      dx0_s = pixel_x - x0_r;
      dx1_s = x1_r - pixel_x;
      dy0_s = pixel_y - y0_r;
      dy1_s = y1_r - pixel_y;
      in_box_s = (pixel_x >= x0_r) && (pixel_x <= x1_r) &&
                 (pixel_y >= y0_r) && (pixel_y <= y1_r);
      if (in_box_s) begin
         on_border_s = (dx0_s < BW) || (dx1_s < BW) ||
                       (dy0_s < BW) || (dy1_s < BW);
      end else begin
         on_border_s = 1'b0;
      end
`ifdef VGA_BLINK_EN
      // blank phase: border pixels fall through to the interior colour
      if (frame_cnt_r[BLINK_LOG2]) begin
         on_border_s = 1'b0;
      end else begin
         on_border_s = on_border_s;
      end
`endif
   end

   // stage 1 registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_box_r    <= 1'b0;
         on_border_r <= 1'b0;
         vid_r       <= 1'b0;
         hs1_r       <= 1'b0;
         vs1_r       <= 1'b0;
      end else if (pixel_tick) begin
         in_box_r    <= in_box_s;
         on_border_r <= on_border_s;
         vid_r       <= video_on;
         hs1_r       <= h_sync_in;
         vs1_r       <= v_sync_in;
      end
   end

   // stage 2 colour mux; colours come from the active registers, which
   // are frame-stable, so reading them one tick later is safe
   always_comb begin
      rgb_s = 8'h00;
      if (!vid_r) begin
         rgb_s = 8'h00;
      end else if (on_border_r) begin
         rgb_s = fg_r;
      end else if (in_box_r) begin
         rgb_s = bg_r;
      end else begin
         rgb_s = 8'h00;
      end
   end

   // stage 2 registers drive the outputs directly
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb    <= 8'h00;
         h_sync <= 1'b0;
         v_sync <= 1'b0;
      end else if (pixel_tick) begin
         rgb    <= rgb_s;
         h_sync <= hs1_r;
         v_sync <= vs1_r;
      end
   end

endmodule

// File: tb/tb_vga_box_rgb_gen.sv
// -----------------------------------------------------------------------------
// Testbench for vga_box_rgb_gen (default build, VGA_BLINK_EN undefined).
// Pixel coordinates are driven directly rather than from a full timing
// generator, so a "frame start" is simply a tick presenting pixel (0,0).
// Each pixel tick occupies two clk cycles (pixel_tick high on one of them).
// -----------------------------------------------------------------------------
module tb_vga_box_rgb_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       pixel_tick;
   logic       video_on;
   logic       h_sync_in;
   logic       v_sync_in;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       cfg_we;
   logic [2:0] cfg_addr;
   logic [9:0] cfg_data;
   logic       cfg_pending;
   logic [7:0] rgb;
   logic       h_sync;
   logic       v_sync;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       vid;
      logic       hs;
      logic       vs;
      logic [7:0] exp_rgb;
      logic       exp_hs;
      logic       exp_vs;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   vga_box_rgb_gen dut (
      .clk         (clk),
      .reset       (reset),
      .pixel_tick  (pixel_tick),
      .video_on    (video_on),
      .h_sync_in   (h_sync_in),
      .v_sync_in   (v_sync_in),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .cfg_pending (cfg_pending),
      .rgb         (rgb),
      .h_sync      (h_sync),
      .v_sync      (v_sync)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // one pixel tick: inputs set at negedge, tick edge, returns at the next negedge
   task automatic px(input logic [9:0] x, input logic [9:0] y, input logic vid,
                     input logic hs, input logic vs);
      @(negedge clk);
      pixel_x    = x;
      pixel_y    = y;
      video_on   = vid;
      h_sync_in  = hs;
      v_sync_in  = vs;
      pixel_tick = 1'b1;
      @(negedge clk);
      pixel_tick = 1'b0;
   endtask

   // filler pixel outside every box used here, never (0,0)
   task automatic filler();
      px(10'd20, 10'd20, 1'b0, 1'b0, 1'b0);
   endtask

   // colour of a single visible pixel, checked two ticks after it is presented
   task automatic pix_chk(input string name, input logic [9:0] x, input logic [9:0] y,
                          input logic [7:0] exp);
      px(x, y, 1'b1, 1'b0, 1'b0);
      filler();
      chk(name, {2'b00, rgb}, {2'b00, exp});
   endtask

   task automatic cfg_wr(input logic [2:0] a, input logic [9:0] d);
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      @(negedge clk);
      cfg_we   = 1'b0;
   endtask

   task automatic commit();
      px(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      vecs[0]  = '{10'd100, 10'd100, 1'b1, 1'b0, 1'b0, 8'hE0, 1'b0, 1'b0};
      vecs[1]  = '{10'd300, 10'd200, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
      vecs[2]  = '{10'd50,  10'd50,  1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[3]  = '{10'd103, 10'd200, 1'b1, 1'b0, 1'b0, 8'hE0, 1'b0, 1'b0};
      vecs[4]  = '{10'd104, 10'd200, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
      vecs[5]  = '{10'd539, 10'd379, 1'b1, 1'b0, 1'b0, 8'hE0, 1'b0, 1'b0};
      vecs[6]  = '{10'd540, 10'd200, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[7]  = '{10'd536, 10'd200, 1'b1, 1'b0, 1'b0, 8'hE0, 1'b0, 1'b0};
      vecs[8]  = '{10'd535, 10'd200, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
      vecs[9]  = '{10'd300, 10'd376, 1'b1, 1'b0, 1'b0, 8'hE0, 1'b0, 1'b0};
      vecs[10] = '{10'd300, 10'd375, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
      vecs[11] = '{10'd300, 10'd200, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[12] = '{10'd100, 10'd100, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[13] = '{10'd300, 10'd99,  1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[14] = '{10'd650, 10'd490, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[15] = '{10'd10,  10'd490, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};

      // reset with active-looking inputs; nothing may propagate
      reset      = 1'b1;
      pixel_tick = 1'b1;
      video_on   = 1'b1;
      h_sync_in  = 1'b1;
      v_sync_in  = 1'b1;
      pixel_x    = 10'd100;
      pixel_y    = 10'd100;
      cfg_we     = 1'b0;
      cfg_addr   = 3'd0;
      cfg_data   = 10'd0;
      repeat (3) @(negedge clk);
      chk("reset_rgb",     {2'b00, rgb}, 10'h000);
      chk("reset_hsync",   {9'd0, h_sync}, 10'd0);
      chk("reset_vsync",   {9'd0, v_sync}, 10'd0);
      chk("reset_pending", {9'd0, cfg_pending}, 10'd0);
      pixel_tick = 1'b0;
      reset      = 1'b0;

      // table: output after the tick of vector i reflects vector i-1
      for (int i = 0; i <= NV; i++) begin
         if (i < NV) px(vecs[i].x, vecs[i].y, vecs[i].vid, vecs[i].hs, vecs[i].vs);
         else        filler();
         if (i > 0) begin
            chk($sformatf("vec%0d_rgb", i-1), {2'b00, rgb}, {2'b00, vecs[i-1].exp_rgb});
            chk($sformatf("vec%0d_hs", i-1), {9'd0, h_sync}, {9'd0, vecs[i-1].exp_hs});
            chk($sformatf("vec%0d_vs", i-1), {9'd0, v_sync}, {9'd0, vecs[i-1].exp_vs});
         end
      end

      // pipeline holds while pixel_tick is low
      px(10'd100, 10'd100, 1'b1, 1'b0, 1'b0);
      filler();
      chk("hold_pre", {2'b00, rgb}, 10'h0E0);
      pixel_x   = 10'd300;
      pixel_y   = 10'd200;
      video_on  = 1'b1;
      h_sync_in = 1'b1;
      v_sync_in = 1'b1;
      repeat (4) @(negedge clk);
      chk("hold_rgb", {2'b00, rgb}, 10'h0E0);
      chk("hold_hs",  {9'd0, h_sync}, 10'd0);

      // h_sync pulse 656..751 must come out two ticks later
      for (int x = 654; x <= 756; x++) begin
         px(10'(x), 10'd10, 1'b0, (x >= 656 && x <= 751), 1'b0);
         if (x > 654) chk($sformatf("hs_align_x%0d", x), {9'd0, h_sync},
                          {9'd0, ((x-1) >= 656 && (x-1) <= 751)});
      end
      // v_sync pulse on rows 490..491
      for (int y = 488; y <= 494; y++) begin
         px(10'd10, 10'(y), 1'b0, 1'b0, (y >= 490 && y <= 491));
         if (y > 488) chk($sformatf("vs_align_y%0d", y), {9'd0, v_sync},
                          {9'd0, ((y-1) >= 490 && (y-1) <= 491)});
      end

      // mid-frame X0 write stays in shadow until frame start
      cfg_wr(3'd0, 10'd10);
      chk("x0_pending_set", {9'd0, cfg_pending}, 10'd1);
      pix_chk("x0_midframe_10_100", 10'd10, 10'd100, 8'h00);
      pix_chk("x0_midframe_100_100", 10'd100, 10'd100, 8'hE0);
      commit();
      chk("x0_pending_clr", {9'd0, cfg_pending}, 10'd0);
      pix_chk("x0_new_10_100", 10'd10, 10'd100, 8'hE0);
      pix_chk("x0_new_9_100", 10'd9, 10'd100, 8'h00);
      pix_chk("x0_new_14_200", 10'd14, 10'd200, 8'h03);

      // reserved address leaves everything alone
      cfg_wr(3'd6, 10'h3FF);
      chk("addr6_pending", {9'd0, cfg_pending}, 10'd0);
      pix_chk("addr6_box", 10'd10, 10'd100, 8'hE0);

      // FG write on the exact commit clk lands one frame later
      @(negedge clk);
      pixel_x    = 10'd0;
      pixel_y    = 10'd0;
      video_on   = 1'b0;
      h_sync_in  = 1'b0;
      v_sync_in  = 1'b0;
      pixel_tick = 1'b1;
      cfg_we     = 1'b1;
      cfg_addr   = 3'd4;
      cfg_data   = 10'h31C;
      @(negedge clk);
      pixel_tick = 1'b0;
      cfg_we     = 1'b0;
      chk("samecl_pending", {9'd0, cfg_pending}, 10'd1);
      pix_chk("samecl_next_frame", 10'd10, 10'd200, 8'hE0);
      commit();
      chk("samecl_pending_clr", {9'd0, cfg_pending}, 10'd0);
      pix_chk("samecl_frame_after", 10'd10, 10'd200, 8'h1C);

      // border wider than the box: whole box is FG
      cfg_wr(3'd0, 10'd300);
      cfg_wr(3'd2, 10'd305);
      cfg_wr(3'd1, 10'd200);
      cfg_wr(3'd3, 10'd205);
      commit();
      pix_chk("tiny_center", 10'd303, 10'd203, 8'h1C);
      pix_chk("tiny_outside", 10'd306, 10'd203, 8'h00);

      // empty box (X0 > X1 by one): frame black
      cfg_wr(3'd0, 10'd400);
      cfg_wr(3'd2, 10'd399);
      commit();
      pix_chk("empty_400", 10'd400, 10'd203, 8'h00);
      pix_chk("empty_399", 10'd399, 10'd203, 8'h00);

      // asynchronous reset mid-frame
      cfg_wr(3'd2, 10'd450);
      commit();
      pix_chk("prereset_rgb", 10'd400, 10'd200, 8'h1C);
      cfg_wr(3'd0, 10'd50);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_rgb", {2'b00, rgb}, 10'h000);
      chk("async_reset_pending", {9'd0, cfg_pending}, 10'd0);
      @(negedge clk);
      reset = 1'b0;
      pix_chk("post_reset_border", 10'd100, 10'd100, 8'hE0);
      pix_chk("post_reset_interior", 10'd300, 10'd200, 8'h03);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
